// File: rtl/hdmi_stream_aligner.sv
// hdmi_stream_aligner
//   Live-video stage between hdmi_generator and the HDMI pins. A valid/ready
//   pixel stream tagged with start-of-frame markers is buffered in a small
//   FIFO. One pixel is popped per generator request. The timing strobes are
//   re-timed so that data_out is cycle-aligned with de_out. Underflow and
//   frame misalignment blank the output, and the block re-locks on the next
//   frame start.
//
// Ports
//   clock, reset            pixel clock, asynchronous active-low reset
//   s_data/s_sof/s_valid    input pixel stream; s_ready is FIFO-not-full
//   hs_in/vs_in/de_in/vclock_in, request, x, y   timing and request from the generator
//   hs_out/vs_out/de_out/vclock_out, data_out    timing and pixel, 2 cycles later
//   locked, underflow, misalign, clear_status    status; flags are sticky until cleared
//   level                   FIFO occupancy
module hdmi_stream_aligner #(
  parameter int HBW   = 12,
  parameter int VBW   = 11,
  parameter int DW    = 36,
  parameter int DEPTH = 16,              // power of two, >= 4
  parameter logic [DW-1:0] BLANK = {DW{1'b0}}
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_sof,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     hs_in,
  input  logic                     vs_in,
  input  logic                     de_in,
  input  logic                     vclock_in,
  input  logic                     request,
  input  logic [HBW-1:0]           x,
  input  logic [VBW-1:0]           y,
  output logic                     hs_out,
  output logic                     vs_out,
  output logic                     de_out,
  output logic                     vclock_out,
  output logic [DW-1:0]            data_out,
  output logic                     locked,
  output logic                     underflow,
  output logic                     misalign,
  input  logic                     clear_status,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [DW:0]      mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r, count_nxt_s;
  logic             s_ready_r;
  logic             push_s, pop_s, empty_s, origin_s;
  logic [DW:0]      head_s;
  logic [DW-1:0]    pix_s;
  logic             ufl_set_s, mis_set_s;
  logic             underflow_r, misalign_r;
  logic [3:0]       tim_d1_r, tim_d2_r;
  logic [DW-1:0]    pix_d1_r, data_out_r;
  logic             lock_d1_r, locked_r;

  // s_ready_r already encodes !full of the current occupancy, so a pop in a
  // full cycle cannot admit a push in the same cycle.
  assign push_s   = s_valid & s_ready_r;
  assign empty_s  = (count_r == {(AW+1){1'b0}});
  assign head_s   = mem_r[rd_ptr_r];
  assign origin_s = (x == {HBW{1'b0}}) && (y == {VBW{1'b0}});

  // FIFO storage write; contents need no reset because pointers gate all reads.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {s_sof, s_data};
    end
  end

  // Next occupancy from push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 1'b1;
      2'b01:   count_nxt_s = count_r - 1'b1;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {(AW+1){1'b0}};
      s_ready_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r   <= count_nxt_s;
      s_ready_r <= (count_nxt_s != FULL_LVL);
    end
  end

  // Lock state machine: next state, pop decision and pixel selection.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    pix_s       = BLANK;
    ufl_set_s   = 1'b0;
    mis_set_s   = 1'b0;
    case (state_r)
      HUNT: begin
        // Drain everything up to the next frame start.
        if (!empty_s) begin
          if (head_s[DW]) begin
            state_nxt_s = ARMED;
          end else begin
            pop_s = 1'b1;
          end
        end else begin
          state_nxt_s = HUNT;
        end
      end
      ARMED: begin
        if (request && origin_s && !empty_s) begin
          pop_s       = 1'b1;
          pix_s       = head_s[DW-1:0];
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      RUN: begin
        if (request) begin
          if (empty_s) begin
            ufl_set_s   = 1'b1;
            state_nxt_s = HUNT;
          end else if (head_s[DW] && !origin_s) begin
            // Early frame start: keep it and wait for the generator's origin.
            mis_set_s   = 1'b1;
            state_nxt_s = ARMED;
          end else if (origin_s && !head_s[DW]) begin
            mis_set_s   = 1'b1;
            state_nxt_s = HUNT;
          end else begin
            pop_s = 1'b1;
            pix_s = head_s[DW-1:0];
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = HUNT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sticky status flags; a set event wins over a simultaneous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underflow_r <= 1'b0;
      misalign_r  <= 1'b0;
    end else begin
      if (ufl_set_s)         underflow_r <= 1'b1;
      else if (clear_status) underflow_r <= 1'b0;
      else                   underflow_r <= underflow_r;
      if (mis_set_s)         misalign_r  <= 1'b1;
      else if (clear_status) misalign_r  <= 1'b0;
      else                   misalign_r  <= misalign_r;
    end
  end

  // Two-stage output pipeline. locked follows the state being entered so it
  // rises together with the first pixel of a lock and falls with the blank.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tim_d1_r   <= 4'b0000;
      tim_d2_r   <= 4'b0000;
      pix_d1_r   <= {DW{1'b0}};
      data_out_r <= {DW{1'b0}};
      lock_d1_r  <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      tim_d1_r   <= {hs_in, vs_in, de_in, vclock_in};
      tim_d2_r   <= tim_d1_r;
      pix_d1_r   <= pix_s;
      data_out_r <= pix_d1_r;
      lock_d1_r  <= (state_nxt_s == RUN);
      locked_r   <= lock_d1_r;
    end
  end

  assign s_ready    = s_ready_r;
  assign level      = count_r;
  assign hs_out     = tim_d2_r[3];
  assign vs_out     = tim_d2_r[2];
  assign de_out     = tim_d2_r[1];
  assign vclock_out = tim_d2_r[0];
  assign data_out   = data_out_r;
  assign locked     = locked_r;
  assign underflow  = underflow_r;
  assign misalign   = misalign_r;

endmodule

// File: tb/tb_hdmi_stream_aligner.sv
module tb_hdmi_stream_aligner;
  localparam int HBW = 12;
  localparam int VBW = 11;
  localparam int DW = 36;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_sof = 1'b0, s_valid = 1'b0, s_ready;
  logic hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0, vclock_in = 1'b0;
  logic request = 1'b0;
  logic [HBW-1:0] x = '0;
  logic [VBW-1:0] y = '0;
  logic hs_out, vs_out, de_out, vclock_out;
  logic [DW-1:0] data_out;
  logic locked, underflow, misalign;
  logic clear_status = 1'b0;
  logic [$clog2(DEPTH):0] level;

  hdmi_stream_aligner #(.HBW(HBW), .VBW(VBW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .vclock_in(vclock_in),
    .request(request), .x(x), .y(y),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .vclock_out(vclock_out),
    .data_out(data_out), .locked(locked), .underflow(underflow), .misalign(misalign),
    .clear_status(clear_status), .level(level)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          lk;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] px(input int f, input int i);
    return 36'h9_0000_0000 + 36'(f * 16 + i);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_px(input logic [DW-1:0] d, input logic sof);
    int budget;
    budget = 50;
    s_valid = 1'b1; s_data = d; s_sof = sof;
    @(negedge clock);
    while (!s_ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (!s_ready) check("push_timeout", 64'(s_ready), 64'(1));
    step();
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic push_frame(input int f, input int n);
    for (int i = 0; i < n; i++) push_px(px(f, i), (i == 0));
  endtask

  // One request; the expected pixel/lock is queued for the monitor.
  task automatic req(input int xx, input int yy, input logic [DW-1:0] ed, input logic el);
    request = 1'b1; de_in = 1'b1;
    x = HBW'(xx); y = VBW'(yy);
    sb_q.push_back(exp_t'{data: ed, lk: el});
    step();
    request = 1'b0; de_in = 1'b0;
  endtask

  // 4x2 active area with two blanking cycles between lines.
  task automatic req_frame(input int f);
    for (int i = 0; i < 8; i++) begin
      req(i % 4, i / 4, px(f, i), 1'b1);
      if (i == 3) begin step(); step(); end
    end
  endtask

  // Free-running hs/vs/vclock patterns.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      hs_in = cyc[1] ^ cyc[3];
      vs_in = cyc[4];
      vclock_in = cyc[0];
    end
  end

  // Monitor: timing delay check every cycle, scoreboard pop on each de_out.
  initial begin
    int hcnt;
    logic [3:0] d1, d2;
    exp_t e;
    hcnt = 0; d1 = 4'b0; d2 = 4'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hcnt = 0;
        sb_q.delete();
      end else begin
        if (hcnt >= 2) check("timing_delay", 64'({hs_out, vs_out, de_out, vclock_out}), 64'(d2));
        d2 = d1;
        d1 = {hs_in, vs_in, de_in, vclock_in};
        if (hcnt < 2) hcnt++;
        if (de_out) begin
          if (sb_q.size() == 0) begin
            check("unexpected_pixel", 64'(data_out), 64'(0));
            if (data_out === '0) check("unexpected_pixel_no_request", 64'(1), 64'(0));
          end else begin
            e = sb_q.pop_front();
            check("pixel", 64'(data_out), 64'(e.data));
            check("locked_with_pixel", 64'(locked), 64'(e.lk));
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    logic acc_now;

    // Reset state.
    repeat (3) @(posedge clock);
    #2;
    check("reset_outputs", 64'({s_ready, hs_out, vs_out, de_out, vclock_out, locked, underflow, misalign}), 64'(0));
    check("reset_data", 64'(data_out), 64'(0));
    check("reset_level", 64'(level), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    step();
    @(negedge clock);
    check("ready_after_release", 64'(s_ready), 64'(1));
    step();

    // HUNT discards non-sof data.
    for (int k = 0; k < 3; k++) push_px(px(15, k), 1'b0);
    repeat (3) step();
    @(negedge clock);
    check("hunt_discard_level", 64'(level), 64'(0));
    check("hunt_not_locked", 64'(locked), 64'(0));
    step();
    push_frame(0, 8);
    req_frame(0);

    // Steady-state frames.
    for (int f = 1; f < 4; f++) begin
      push_frame(f, 8);
      req_frame(f);
    end

    // Underflow after 5 of 8 pixels.
    push_frame(4, 5);
    for (int i = 0; i < 5; i++) req(i % 4, i / 4, px(4, i), 1'b1);
    req(1, 1, 36'h0, 1'b0);
    req(2, 1, 36'h0, 1'b0);
    req(3, 1, 36'h0, 1'b0);
    repeat (3) step();
    @(negedge clock);
    check("underflow_set", 64'(underflow), 64'(1));
    check("underflow_unlocked", 64'(locked), 64'(0));
    step();
    push_frame(5, 8);
    req_frame(5);
    repeat (3) step();
    @(negedge clock);
    check("underflow_sticky", 64'(underflow), 64'(1));
    check("relocked", 64'(locked), 64'(1));
    step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    @(negedge clock);
    check("underflow_cleared", 64'(underflow), 64'(0));
    step();

    // Misalign: early sof at (2,0).
    push_px(px(6, 0), 1'b1);
    push_px(px(6, 1), 1'b0);
    push_frame(7, 8);
    req(0, 0, px(6, 0), 1'b1);
    req(1, 0, px(6, 1), 1'b1);
    req(2, 0, 36'h0, 1'b0);
    @(negedge clock);
    check("misalign_no_pop_level", 64'(level), 64'(8));
    step();
    req(3, 0, 36'h0, 1'b0);
    for (int i = 4; i < 8; i++) req(i % 4, i / 4, 36'h0, 1'b0);
    req_frame(7);
    repeat (3) step();
    @(negedge clock);
    check("misalign_set", 64'(misalign), 64'(1));
    check("misalign_drained", 64'(level), 64'(0));
    step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    @(negedge clock);
    check("misalign_cleared", 64'(misalign), 64'(0));
    step();

    // Full FIFO with request held low.
    accepted = 0;
    s_valid = 1'b1;
    for (int k = 0; k < DEPTH + 3; k++) begin
      s_data = px(8, accepted);
      s_sof = (accepted == 0);
      @(negedge clock);
      acc_now = s_ready;
      step();
      if (acc_now) accepted++;
    end
    s_data = px(8, accepted); s_sof = 1'b0;
    check("full_accepted", 64'(accepted), 64'(DEPTH));
    @(negedge clock);
    check("full_level", 64'(level), 64'(DEPTH));
    check("full_not_ready", 64'(s_ready), 64'(0));
    step();
    // Pop while full with s_valid still high: no push may land.
    request = 1'b1; de_in = 1'b1; x = '0; y = '0;
    sb_q.push_back(exp_t'{data: px(8, 0), lk: 1'b1});
    @(negedge clock);
    check("pop_full_not_ready", 64'(s_ready), 64'(0));
    step();
    request = 1'b0; de_in = 1'b0; s_valid = 1'b0;
    @(negedge clock);
    check("pop_full_level", 64'(level), 64'(DEPTH - 1));
    step();
    for (int i = 1; i < 6; i++) req(i % 4, i / 4, px(8, i), 1'b1);
    repeat (4) step();

    // Asynchronous reset mid-frame.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 64'({s_ready, hs_out, vs_out, de_out, vclock_out, locked, underflow, misalign}), 64'(0));
    check("async_reset_data", 64'(data_out), 64'(0));
    check("async_reset_level", 64'(level), 64'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();
    @(negedge clock);
    check("post_reset_level", 64'(level), 64'(0));
    check("post_reset_ready", 64'(s_ready), 64'(1));
    check("post_reset_unlocked", 64'(locked), 64'(0));
    step();
    push_px(px(9, 15), 1'b0);
    push_frame(9, 8);
    req_frame(9);
    repeat (5) step();
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
